// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM state
// encodings and the default statistics counter width.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } ctrl_state_e;

  localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_ONE = W'(1);
  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] r_count;

  // Count register: holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= {W{1'b0}};
    end else if (clr) begin
      r_count <= {W{1'b0}};
    end else if (inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Freeze/flush/bubble generation for the 5-stage core: fixed priority of memory
// stall over taken branch over RAW hazard, with a memory-wait timeout FSM.
module pipeline_stall_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_cnt,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic             freeze_back,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
);

  localparam int              WR_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WR_W-1:0] WR_ONE = WR_W'(1);
  localparam logic [WR_W-1:0] WR_MAX = WR_W'(MEM_TIMEOUT);

  ctrl_state_e     r_state;
  logic [WR_W-1:0] r_wait_run;
  logic            r_timeout_err;

  logic w_mem_stall;
  logic w_prio_mem;
  logic w_prio_branch;
  logic w_prio_hazard;
  logic w_in_err;

  assign w_mem_stall = mem_req && !mem_ready;

  // Priority resolution; every class is masked while rst is asserted.
  always_comb begin
    w_prio_mem    = 1'b0;
    w_prio_branch = 1'b0;
    w_prio_hazard = 1'b0;
    w_in_err      = 1'b0;
    if (rst) begin
      w_in_err = 1'b0;
    end else begin
      case (r_state)
        ST_RUN, ST_MEM_WAIT: begin
          if (w_mem_stall) begin
            w_prio_mem = 1'b1;
          end else if (branch_taken) begin
            w_prio_branch = 1'b1;
          end else if (hazard_detected) begin
            w_prio_hazard = 1'b1;
          end else begin
            w_prio_mem = 1'b0;
          end
        end
        ST_ERR:  w_in_err = 1'b1;
        default: w_in_err = 1'b0;
      endcase
    end
  end

  assign freeze_pc    = w_prio_mem | w_prio_hazard | w_in_err;
  assign freeze_if_id = w_prio_mem | w_prio_hazard | w_in_err;
  assign flush_if_id  = w_prio_branch;
  assign bubble_id_ex = w_prio_branch | w_prio_hazard;
  assign freeze_back  = w_prio_mem | w_in_err;
  assign timeout_err  = r_timeout_err;

  // State, memory-wait run length and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_wait_run    <= {WR_W{1'b0}};
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_stall) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_run <= WR_ONE;
          end else begin
            r_state    <= ST_RUN;
            r_wait_run <= {WR_W{1'b0}};
          end
        end
        ST_MEM_WAIT: begin
          if (w_mem_stall) begin
            if (r_wait_run == WR_MAX) begin
              r_state       <= ST_ERR;
              r_timeout_err <= 1'b1;
            end else begin
              r_wait_run <= r_wait_run + WR_ONE;
            end
          end else begin
            r_state    <= ST_RUN;
            r_wait_run <= {WR_W{1'b0}};
          end
        end
        ST_ERR: begin
          r_state       <= ST_ERR;
          r_timeout_err <= 1'b1;
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_run <= {WR_W{1'b0}};
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (w_prio_hazard),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (w_prio_branch),
    .count (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mem_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (w_prio_mem),
    .count (mem_wait_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

  localparam int CW   = 3;
  localparam int TO   = 4;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_HAZ  = 5'b11010;
  localparam logic [4:0] C_BR   = 5'b00110;
  localparam logic [4:0] C_MEM  = 5'b11001;

  logic clk = 1'b0;
  logic rst, hazard_detected, branch_taken, mem_req, mem_ready, clr_cnt;
  logic freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex, freeze_back, timeout_err;
  logic [CW-1:0] stall_cnt, flush_cnt, mem_wait_cnt;
  logic [4:0] ctl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ctl = {freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex, freeze_back};

  pipeline_stall_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
    .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .flush_if_id(flush_if_id),
    .bubble_id_ex(bubble_id_ex), .freeze_back(freeze_back), .timeout_err(timeout_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_wait_cnt(mem_wait_cnt)
  );

  task automatic drive(input logic r, input logic h, input logic b, input logic q,
                       input logic y, input logic c);
    rst = r; hazard_detected = h; branch_taken = b; mem_req = q; mem_ready = y; clr_cnt = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== C_NONE) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_NONE); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({timeout_err, stall_cnt, flush_cnt, mem_wait_cnt} !== {1'b0, {3*CW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_state: got terr=%b cnt=%0d/%0d/%0d expected all 0",
               timeout_err, stall_cnt, flush_cnt, mem_wait_cnt);
    end
  endtask

  task automatic test_hazard_stall();
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl !== C_HAZ) begin errors++; $display("FAIL hazard_ctl: got %b expected %b", ctl, C_HAZ); end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall_cnt !== 3'd2) begin errors++; $display("FAIL hazard_cnt: got %0d expected 2", stall_cnt); end
  endtask

  task automatic test_branch_over_hazard();
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== C_BR) begin errors++; $display("FAIL branch_ctl: got %b expected %b", ctl, C_BR); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({flush_cnt, stall_cnt} !== {3'd1, 3'd0}) begin
      errors++; $display("FAIL branch_cnt: got flush=%0d stall=%0d expected 1/0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_mem_over_branch();
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== C_MEM) begin errors++; $display("FAIL memstall_ctl: cycle %0d got %b expected %b", i, ctl, C_MEM); end
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    checks++;
    if (ctl !== C_BR) begin errors++; $display("FAIL advance_ctl: got %b expected %b", ctl, C_BR); end
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== C_HAZ) begin errors++; $display("FAIL back_in_run: got %b expected %b", ctl, C_HAZ); end
    checks++;
    if ({mem_wait_cnt, flush_cnt} !== {3'd3, 3'd1}) begin
      errors++; $display("FAIL memstall_cnt: got mw=%0d flush=%0d expected 3/1", mem_wait_cnt, flush_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i <= TO; i++) begin
      #1;
      checks++;
      if ({ctl, timeout_err} !== {C_MEM, 1'b0}) begin
        errors++; $display("FAIL timeout_pre: cycle %0d got ctl=%b terr=%b expected %b/0", i, ctl, timeout_err, C_MEM);
      end
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({ctl, timeout_err, mem_wait_cnt} !== {C_MEM, 1'b1, 3'd5}) begin
        errors++; $display("FAIL timeout_err_state: got ctl=%b terr=%b mw=%0d expected %b/1/5",
                           ctl, timeout_err, mem_wait_cnt, C_MEM);
      end
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== C_NONE) begin errors++; $display("FAIL err_rst_ctl: got %b expected %b", ctl, C_NONE); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({ctl, timeout_err, stall_cnt, flush_cnt, mem_wait_cnt} !== {C_NONE, 1'b0, {3*CW{1'b0}}}) begin
      errors++; $display("FAIL err_after_rst: got ctl=%b terr=%b mw=%0d expected all 0", ctl, timeout_err, mem_wait_cnt);
    end
  endtask

  task automatic test_saturation_clear();
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (int'(stall_cnt) != ((i < CMAX) ? i : CMAX)) begin
        errors++; $display("FAIL sat_cnt: cycle %0d got %0d expected %0d", i, stall_cnt, (i < CMAX) ? i : CMAX);
      end
      tick();
    end
    checks++;
    if (stall_cnt !== 3'd7) begin errors++; $display("FAIL sat_hold: got %0d expected 7", stall_cnt); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall_cnt !== 3'd0) begin errors++; $display("FAIL clr_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== C_NONE) begin errors++; $display("FAIL midwait_rst_ctl: got %b expected %b", ctl, C_NONE); end
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({ctl, stall_cnt, flush_cnt, mem_wait_cnt} !== {C_HAZ, {3*CW{1'b0}}}) begin
      errors++; $display("FAIL midwait_after_rst: got ctl=%b mw=%0d expected %b/0", ctl, mem_wait_cnt, C_HAZ);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (TO) tick();
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL midwait_run_cleared: got terr=%b expected 0", timeout_err); end
  endtask

  task automatic test_random();
    int m_run, m_stall, m_flush, m_mw, thr;
    bit m_err, ms;
    logic [4:0] exp_ctl;
    logic r, h, b, q, y, c;
    do_reset();
    m_run = 0; m_stall = 0; m_flush = 0; m_mw = 0; m_err = 1'b0; thr = 5;
    for (int n = 0; n < 600; n++) begin
      if (n % 40 == 0) thr = $urandom_range(0, 9);
      r = ($urandom_range(0, 79) == 0);
      c = ($urandom_range(0, 29) == 0);
      h = $urandom_range(0, 1);
      b = ($urandom_range(0, 3) == 0);
      q = ($urandom_range(0, 9) < 7);
      y = ($urandom_range(0, 9) < thr);
      drive(r, h, b, q, y, c);
      ms = q && !y;
      if (r)          exp_ctl = C_NONE;
      else if (m_err) exp_ctl = C_MEM;
      else if (ms)    exp_ctl = C_MEM;
      else if (b)     exp_ctl = C_BR;
      else if (h)     exp_ctl = C_HAZ;
      else            exp_ctl = C_NONE;
      #1;
      checks++;
      if (ctl !== exp_ctl) begin errors++; $display("FAIL rand_ctl: step %0d got %b expected %b", n, ctl, exp_ctl); end
      checks++;
      if (timeout_err !== m_err || int'(stall_cnt) != m_stall || int'(flush_cnt) != m_flush ||
          int'(mem_wait_cnt) != m_mw) begin
        errors++;
        $display("FAIL rand_state: step %0d got terr=%b cnt=%0d/%0d/%0d expected %b %0d/%0d/%0d",
                 n, timeout_err, stall_cnt, flush_cnt, mem_wait_cnt, m_err, m_stall, m_flush, m_mw);
      end
      tick();
      if (r) begin
        m_run = 0; m_stall = 0; m_flush = 0; m_mw = 0; m_err = 1'b0;
      end else if (c) begin
        m_stall = 0; m_flush = 0; m_mw = 0;
      end else if (!m_err) begin
        if (ms)     m_mw    = (m_mw    < CMAX) ? m_mw + 1    : CMAX;
        else if (b) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        else if (h) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      end
      if (!r && !m_err) begin
        m_run = ms ? m_run + 1 : 0;
        if (m_run == TO + 1) m_err = 1'b1;
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_hazard_stall();
    test_branch_over_hazard();
    test_mem_over_branch();
    test_timeout();
    test_saturation_clear();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Responds to the pipeline's hazard and memory-wait conditions by generating the per-stage freeze, flush and bubble controls for the 5-stage ARM core. It consumes `hazard_detected` from the hazard unit, `branch_taken` from EXE, and the SRAM handshake (`mem_req`/`mem_ready`) from MEM. It enforces a fixed priority between these conditions, tracks consecutive memory-wait cycles with a timeout, and keeps saturating stall/flush statistics for debug.

## Interface
- `CNT_W`, 32, width of each statistics counter
- `MEM_TIMEOUT`, 64, consecutive memory-wait cycles that trigger the error state (≥2)
- `clk` in 1: core clock
- `rst` in 1: one clock; reset is synchronous and active-high
- `hazard_detected` in 1: RAW hazard from ID, request to stall
- `branch_taken` in 1: taken branch resolved in EXE
- `mem_req` in 1: MEM stage holds a load/store
- `mem_ready` in 1: SRAM controller completes the access this cycle
- `clr_cnt` in 1: synchronous clear of statistics counters
- `freeze_pc` out 1: hold PC
- `freeze_if_id` out 1: hold IF/ID register
- `flush_if_id` out 1: clear IF/ID register
- `bubble_id_ex` out 1: load NOP controls into ID/EX
- `freeze_back` out 1: hold ID/EX, EXE/MEM, MEM/WB
- `timeout_err` out 1: sticky memory timeout
- `stall_cnt` out CNT_W: hazard stall cycles
- `flush_cnt` out CNT_W: branch flush events
- `mem_wait_cnt` out CNT_W: memory freeze cycles

## Operation
- `mem_stall` = `mem_req && !mem_ready`.
- States: RUN, MEM_WAIT, ERR.
- Control outputs are combinational from state and inputs. While `rst`=1, all control outputs are 0.
- Priority in RUN and MEM_WAIT:
  1. **`mem_stall`**: `freeze_pc`=`freeze_if_id`=`freeze_back`=1. No flush, no bubble. A pending branch or hazard is re-evaluated when the stall ends.
  2. **`branch_taken`**: `flush_if_id`=`bubble_id_ex`=1. No freeze; PC loads the target.
  3. **`hazard_detected`**: `freeze_pc`=`freeze_if_id`=`bubble_id_ex`=1.
  4. **Otherwise**: all controls are 0.
- Transitions:
  - RUN→MEM_WAIT when `mem_stall`. `wait_run` is set to 1.
  - MEM_WAIT, `mem_stall`:
    - If `wait_run`==MEM_TIMEOUT, go to ERR.
    - Otherwise increment `wait_run`.
  - MEM_WAIT, `!mem_stall`: go to RUN and clear `wait_run`.
  - ERR is left only by `rst`.
- ERR behaviour: `freeze_pc`=`freeze_if_id`=`freeze_back`=1 and `timeout_err`=1 every cycle. No flush or bubble. Counters are frozen.
- Counters:
  - `stall_cnt` +1 per priority-3 cycle.
  - `flush_cnt` +1 per priority-2 cycle.
  - `mem_wait_cnt` +1 per priority-1 cycle.
  - All saturate at 2^CNT_W−1 with no wrap.
  - `clr_cnt` zeroes all three and wins over increment. It does not affect state, `wait_run` or `timeout_err`.
- Reset values: state RUN, `wait_run` 0, all counters 0, `timeout_err` 0.

## Timing
- Controls have zero latency: they act in the same cycle as the causing inputs.
- Counters and `timeout_err` update at the clock edge ending the qualifying cycle.
- ERR is entered at the edge ending freeze cycle number MEM_TIMEOUT+1 of an unbroken `mem_stall` run. The MEM_TIMEOUT+1 freeze cycles preceding ERR are counted in `mem_wait_cnt`.
- A `mem_ready`=1 cycle in MEM_WAIT is an advance cycle. Priorities 2 and 3 apply in that cycle and the state is RUN on the next cycle.
- `rst` mid-stall or in ERR: controls go low during the reset cycle, and the state is RUN from the following cycle.

## Structure
- Shared package `pipeline_ctrl_pkg`: state encodings RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2, and default CNT_W.
- Sub-module `sat_counter` (parameter W; ports `clk`, `rst`, `clr`, `inc`, `count`), instantiated three times.
- Top level holds the FSM, `wait_run` (width $clog2(MEM_TIMEOUT+1)) and the priority logic.

## Test plan
- **Hazard stall:** `hazard_detected`=1 for 2 cycles, others 0 → `freeze_pc`/`freeze_if_id`/`bubble_id_ex`=1 both cycles, `freeze_back`=0, `stall_cnt`=2.
- **Branch over hazard:** `branch_taken`=1 and `hazard_detected`=1 together → `flush_if_id`=`bubble_id_ex`=1, `freeze_pc`=0, `flush_cnt`=1, `stall_cnt`=0.
- **Memory stall over branch:** `mem_req`=1, `mem_ready`=0 for 3 cycles, `branch_taken`=1 throughout, then `mem_ready`=1 → 3 cycles with `freeze_back`=1 and no flush; the 4th cycle has `flush_if_id`=1; `mem_wait_cnt`=3, `flush_cnt`=1, state RUN.
- **Timeout:** MEM_TIMEOUT=4, `mem_req`=1, `mem_ready`=0 held → `timeout_err` rises after the edge ending the 5th freeze cycle; `mem_wait_cnt`=5 and stays there; freezes stay high until `rst`; after `rst`, all outputs are 0.
- **Saturation and clear:** CNT_W=3, `hazard_detected` held 10 cycles → `stall_cnt` reaches 7 and holds. Then `clr_cnt`=1 with `hazard_detected`=1 → `stall_cnt`=0 the next cycle.
- **Reset mid-wait:** `rst` pulsed during MEM_WAIT with `wait_run`=3 → all controls 0 that cycle, state RUN, counters 0.
